uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Shares the single TX path of uart_controller between N_REQ independent requesters (e.g. debug console, status reporter, loopback echo). Each requester's request is granted round-robin. The block latches that requester's byte and frame config, drives tx_start/tx_data/tx_conf with the hold-until-done handshake, and returns a per-requester ack. A programmable watchdog aborts transfers whose tx_done never arrives. It sits between the requester logic and uart_controller, driving its tx_* inputs directly.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_UART_DATA_W, 8, data byte width, matches uart_controller
TOTAL_CONF_W, 5, frame config width (stop + data + parity fields), matches uart_controller
GAP_CYCLES, 2, idle clocks enforced between tx_start deassert and next grant (>=1)
TIMEOUT_W, 20, width of watchdog counter/threshold

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  N_REQ  per-requester transmit request, level
req_data_i  in  N_REQ*MAX_UART_DATA_W  packed bytes, requester k at [k*W +: W]
req_conf_i  in  N_REQ*TOTAL_CONF_W  packed frame configs, same packing
timeout_cycles_i  in  TIMEOUT_W  watchdog threshold in clocks; 0 disables
ack_o  out  N_REQ  one-cycle pulse to owner on successful completion
err_o  out  N_REQ  one-cycle pulse to owner on watchdog abort
busy_o  out  1  high in any state except IDLE
owner_o  out  $clog2(N_REQ)  index of current/last granted requester
tx_en_o  out  1  to uart_controller tx_en_i
tx_start_o  out  1  to uart_controller tx_start_i
tx_data_o  out  MAX_UART_DATA_W  to uart_controller tx_data_i
tx_conf_o  out  TOTAL_CONF_W  to uart_controller tx_conf_i
tx_done_i  in  1  from uart_controller tx_done_o
tx_busy_i  in  1  from uart_controller tx_busy_o

Behaviour:
- All outputs are registered. Reset values: ack_o/err_o/busy_o/tx_start_o/tx_en_o = 0; tx_data_o/tx_conf_o/owner_o = 0; RR pointer = 0; state = IDLE.
- tx_en_o rises on the first clock after rst_ni release. It stays 1 except in ABORT.
- FSM states: IDLE, ACTIVE, ABORT, GAP.
- IDLE: if any req_i bit is high and tx_busy_i=0, grant the first set bit searching from (last_owner+1) mod N_REQ upward with wrap. The first grant after reset searches from index 0.
- On grant (cycle n), latch the owner's data/conf into tx_data_o/tx_conf_o, set owner_o, and set tx_start_o=1 at n+1. The next state is ACTIVE. The watchdog clears to 0.
- ACTIVE: tx_start_o is held at 1. The watchdog increments each clock, saturating.
- ACTIVE, tx_done_i=1: next cycle tx_start_o=0 and ack_o[owner]=1 for exactly one cycle; go to GAP.
- ACTIVE, timeout_cycles_i!=0 and count==timeout_cycles_i-1 without tx_done_i: next cycle tx_start_o=0, tx_en_o=0, err_o[owner]=1 for one cycle; go to ABORT.
- Simultaneous tx_done_i and timeout expiry: done wins, giving ack, not err.
- ABORT: lasts one cycle with tx_en_o=0, forcing uart_controller to reset its TX. tx_en_o returns to 1 on exit; go to GAP.
- GAP: tx_start_o=0 for GAP_CYCLES clocks (counter), then IDLE. The minimum spacing between successive tx_start rising edges is therefore frame time + GAP_CYCLES + 2.
- Requests:
  - Data/conf are sampled only at grant. Later changes on req_data_i/req_conf_i have no effect on the frame in flight.
  - Deasserting req_i after grant does not cancel the transfer; ack/err still pulses.
  - A requester holding req_i after ack is re-queued. It waits its round-robin turn; it is not immediately re-granted if others are requesting.
- timeout_cycles_i is sampled continuously; changing it mid-transfer takes effect immediately. A value of 0 disables the watchdog.
- tx_busy_i=1 in IDLE, e.g. after a partial frame, blocks grants until it clears.
- Async reset mid-ACTIVE: outputs go to reset values immediately, and no ack/err is produced for the interrupted transfer.

Decomposition:
- Shared package uart_pkg:
  - tx_sched_state_t enum (IDLE, ACTIVE, ABORT, GAP).
  - Conf field localparams: STOP_CONF_W=2, DATA_CONF_W=2, parity bit position.
  - get_uart_config function, reused by benches to build req_conf_i.
- One sub-module, uart_rr_arbiter: combinational round-robin pick. Inputs are req vector, pointer and enable; outputs are one-hot grant and index. The pointer register lives in the parent.

Test Plan:
- Single request: req_i=4'b0001, data 0x55, conf 8N1, loopback to uart_controller at 256000 baud -> one tx_start pulse held until tx_done, ack_o[0] one cycle, RX receives 0x55, no err_o.
- Fairness: req_i=4'b1111 held, data 0x11/0x22/0x33/0x44 -> grant order 0,1,2,3,0,..., RX sequence 0x11,0x22,0x33,0x44 repeating, each ack to the correct index.
- Per-requester config: req1 conf 7-bit 2-stop with parity, req2 conf 8N1 -> tx_conf_o switches per grant, RX (reconfigured per frame) shows no parity/stop errors.
- Watchdog: tx_done_i forced 0, timeout_cycles_i=1000 -> err_o[owner] exactly 1000 clocks after tx_start rise, one-cycle tx_en_o low, then GAP and the next requester granted. With timeout_cycles_i=0 the block remains in ACTIVE indefinitely.
- Done/timeout collision: tx_done_i asserted on the exact expiry cycle -> ack_o pulses, err_o stays 0.
- Reset mid-frame: rst_ni low during ACTIVE of owner 2 -> all outputs 0 asynchronously, no ack/err. After release, tx_en_o=1 next cycle, the pointer restarts at 0, and the pending request completes.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame-config field layout and config builder
package uart_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, ABORT, GAP} tx_sched_state_t;
  localparam int STOP_CONF_W = 2;
  localparam int DATA_CONF_W = 2;
  localparam int PARITY_POS  = STOP_CONF_W + DATA_CONF_W;
  localparam int CONF_W      = PARITY_POS + 1;
  // conf = {parity_en, data_bits-5, stop_bits-1}
  function automatic logic [CONF_W-1:0] get_uart_config(input int stop_bits, input int data_bits,
                                                        input logic parity_en);
    return {parity_en, DATA_CONF_W'(data_bits - 5), STOP_CONF_W'(stop_bits - 1)};
  endfunction
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick starting at ptr_i with wrap
module uart_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr_i) + i) % N;
      if (en_i && gnt_o == '0 && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART TX path among N_REQ requesters
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5,
  parameter int GAP_CYCLES      = 2,
  parameter int TIMEOUT_W       = 20
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ*MAX_UART_DATA_W-1:0]    req_data_i,
  input  logic [N_REQ*TOTAL_CONF_W-1:0]       req_conf_i,
  input  logic [TIMEOUT_W-1:0]                timeout_cycles_i,
  output logic [N_REQ-1:0]                    ack_o,
  output logic [N_REQ-1:0]                    err_o,
  output logic                                busy_o,
  output logic [$clog2(N_REQ)-1:0]            owner_o,
  output logic                                tx_en_o,
  output logic                                tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]          tx_data_o,
  output logic [TOTAL_CONF_W-1:0]             tx_conf_o,
  input  logic                                tx_done_i,
  input  logic                                tx_busy_i
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int GW    = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = 1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [TIMEOUT_W-1:0] T_ONE    = 1;
  localparam logic [GW-1:0]        G_ONE    = 1;
  localparam logic [GW-1:0]        G_LAST   = GW'(GAP_CYCLES - 1);
  tx_sched_state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_q, owner_d, gnt_idx;
  logic [N_REQ-1:0] gnt, ack_q, ack_d, err_q, err_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic start_q, start_d, en_q, en_d, busy_q, busy_d, expire;
  logic [MAX_UART_DATA_W-1:0] data_q, data_d;
  logic [TOTAL_CONF_W-1:0] conf_q, conf_d;
  uart_rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE && !tx_busy_i),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );
  assign expire = timeout_cycles_i != '0 && wd_q == timeout_cycles_i - T_ONE;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    start_d = start_q;
    data_d  = data_q;
    conf_d  = conf_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = ACTIVE;
        start_d = 1'b1;
        owner_d = gnt_idx;
        ptr_d   = gnt_idx == IDX_LAST ? '0 : gnt_idx + IDX_ONE;
        data_d  = req_data_i[gnt_idx*MAX_UART_DATA_W +: MAX_UART_DATA_W];
        conf_d  = req_conf_i[gnt_idx*TOTAL_CONF_W +: TOTAL_CONF_W];
        wd_d    = '0;
      end
      ACTIVE: begin
        wd_d = wd_q == '1 ? wd_q : wd_q + T_ONE;
        // done takes priority over a watchdog expiry on the same cycle
        if (tx_done_i) begin
          state_d         = GAP;
          start_d         = 1'b0;
          gap_d           = '0;
          ack_d[owner_q]  = 1'b1;
        end else if (expire) begin
          state_d         = ABORT;
          start_d         = 1'b0;
          err_d[owner_q]  = 1'b1;
        end
      end
      ABORT: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        gap_d   = gap_q + G_ONE;
        state_d = gap_q == G_LAST ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    en_d   = state_d != ABORT;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      conf_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      start_q <= start_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      conf_q  <= conf_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end
  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;
  assign tx_en_o    = en_q;
  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign tx_conf_o  = conf_q;
endmodule
